// File: rtl/lcd_refresh_sequencer.sv
`timescale 1ns/1ps
// lcd_refresh_sequencer
// Drives a 4-bit HD44780-style character LCD. After reset it waits out the
// panel power-up time and performs the 4-bit init, then on each start it
// writes 4 config commands followed by 40 hex characters.
//
// start/ready: start is a one-clk request that is accepted only in a cycle
// where ready is high (IDLE). Any start seen while ready is low is dropped
// and never queued. done pulses for one clk when the last table entry has
// been written, in the same cycle ready returns high.
//
// All delays count us_tick pulses. The counter is cleared on every state
// entry, so a tick that coincides with a state change belongs to the state
// being left, never to the state being entered.
module lcd_refresh_sequencer #(
  parameter int unsigned PWRUP_US    = 15000,
  parameter int unsigned E_PULSE_US  = 1,
  parameter int unsigned CMD_WAIT_US = 40,
  parameter int unsigned CLR_WAIT_US = 1640,
  parameter logic [5:0]  LAST_PTR    = 6'h2B
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       us_tick_i,
  input  logic       start_i,
  input  logic [3:0] hex_nibble_i,
  output logic [5:0] cmd_ptr_o,
  output logic [3:0] lcd_db_o,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic       lcd_e_o,
  output logic       ready_o,
  output logic       done_o,
  output logic [3:0] dbg_state_o
);

  // Post-nibble waits of the 4-bit init sequence (0x3, 0x3, 0x3, 0x2).
  localparam logic [15:0] INIT_WAIT0 = 16'd4100;
  localparam logic [15:0] INIT_WAIT1 = 16'd100;
  localparam logic [15:0] INIT_WAIT2 = 16'd40;

  typedef enum logic [3:0] {
    S_PWRUP,
    S_INIT_SETUP,
    S_INIT_E,
    S_INIT_HOLD,
    S_INIT_WAIT,
    S_IDLE,
    S_FETCH,
    S_HI_SETUP,
    S_HI_E,
    S_HI_HOLD,
    S_LO_SETUP,
    S_LO_E,
    S_LO_HOLD,
    S_WAIT,
    S_NEXT
  } state_t;

  state_t      state_q;
  logic [15:0] cnt_q;
  logic [1:0]  init_idx_q;
  logic [7:0]  byte_q;
  logic [5:0]  cmd_ptr_q;
  logic [3:0]  lcd_db_q;
  logic        lcd_rs_q;
  logic        lcd_e_q;
  logic        ready_q;
  logic        done_q;

  logic [15:0] wait_len;
  logic        wait_hit;
  logic [7:0]  tbl_byte;

  // Number of us ticks the current state must count before it may advance.
  always_comb begin
    wait_len = 16'd1;
    case (state_q)
      S_PWRUP:                  wait_len = 16'(PWRUP_US);
      S_INIT_E, S_HI_E, S_LO_E: wait_len = 16'(E_PULSE_US);
      S_INIT_WAIT: begin
        case (init_idx_q)
          2'd0:    wait_len = INIT_WAIT0;
          2'd1:    wait_len = INIT_WAIT1;
          default: wait_len = INIT_WAIT2;
        endcase
      end
      // Two ticks cover the converter's registered output catching up.
      S_FETCH:                  wait_len = 16'd2;
      S_WAIT:                   wait_len = (cmd_ptr_q == 6'd3) ? 16'(CLR_WAIT_US)
                                                               : 16'(CMD_WAIT_US);
      default:                  wait_len = 16'd1;
    endcase
  end

  // The tick arriving now is the last one the state needs.
  assign wait_hit = us_tick_i && (cnt_q == (wait_len - 16'd1));

  // Byte for the current table entry: fixed commands, then ASCII hex digits.
  always_comb begin
    tbl_byte = 8'h00;
    case (cmd_ptr_q)
      6'd0:    tbl_byte = 8'h28;
      6'd1:    tbl_byte = 8'h06;
      6'd2:    tbl_byte = 8'h0C;
      6'd3:    tbl_byte = 8'h01;
      default: tbl_byte = (hex_nibble_i < 4'd10) ? (8'h30 + {4'h0, hex_nibble_i})
                                                 : (8'h37 + {4'h0, hex_nibble_i});
    endcase
  end

  // Sequencer FSM with registered LCD bus, pointer and status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_PWRUP;
      cnt_q      <= '0;
      init_idx_q <= '0;
      byte_q     <= '0;
      cmd_ptr_q  <= '0;
      lcd_db_q   <= '0;
      lcd_rs_q   <= 1'b0;
      lcd_e_q    <= 1'b0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (us_tick_i) begin
        cnt_q <= cnt_q + 16'd1;
      end
      case (state_q)
        S_PWRUP: begin
          if (wait_hit) begin
            lcd_db_q <= 4'h3;
            lcd_rs_q <= 1'b0;
            state_q  <= S_INIT_SETUP;
            cnt_q    <= '0;
          end
        end
        S_INIT_SETUP: begin
          if (wait_hit) begin
            lcd_e_q <= 1'b1;
            state_q <= S_INIT_E;
            cnt_q   <= '0;
          end
        end
        S_INIT_E: begin
          if (wait_hit) begin
            lcd_e_q <= 1'b0;
            state_q <= S_INIT_HOLD;
            cnt_q   <= '0;
          end
        end
        S_INIT_HOLD: begin
          if (wait_hit) begin
            state_q <= S_INIT_WAIT;
            cnt_q   <= '0;
          end
        end
        S_INIT_WAIT: begin
          if (wait_hit) begin
            cnt_q <= '0;
            if (init_idx_q == 2'd3) begin
              init_idx_q <= '0;
              cmd_ptr_q  <= '0;
              ready_q    <= 1'b1;
              state_q    <= S_IDLE;
            end else begin
              // Third write done means the next nibble is 0x2 (enter 4-bit).
              lcd_db_q   <= (init_idx_q == 2'd2) ? 4'h2 : 4'h3;
              init_idx_q <= init_idx_q + 2'd1;
              state_q    <= S_INIT_SETUP;
            end
          end
        end
        S_IDLE: begin
          cnt_q     <= '0;
          lcd_e_q   <= 1'b0;
          cmd_ptr_q <= '0;
          if (start_i) begin
            ready_q <= 1'b0;
            state_q <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (wait_hit) begin
            byte_q   <= tbl_byte;
            lcd_db_q <= tbl_byte[7:4];
            lcd_rs_q <= (cmd_ptr_q >= 6'd4);
            state_q  <= S_HI_SETUP;
            cnt_q    <= '0;
          end
        end
        S_HI_SETUP: begin
          if (wait_hit) begin
            lcd_e_q <= 1'b1;
            state_q <= S_HI_E;
            cnt_q   <= '0;
          end
        end
        S_HI_E: begin
          if (wait_hit) begin
            lcd_e_q <= 1'b0;
            state_q <= S_HI_HOLD;
            cnt_q   <= '0;
          end
        end
        S_HI_HOLD: begin
          if (wait_hit) begin
            lcd_db_q <= byte_q[3:0];
            state_q  <= S_LO_SETUP;
            cnt_q    <= '0;
          end
        end
        S_LO_SETUP: begin
          if (wait_hit) begin
            lcd_e_q <= 1'b1;
            state_q <= S_LO_E;
            cnt_q   <= '0;
          end
        end
        S_LO_E: begin
          if (wait_hit) begin
            lcd_e_q <= 1'b0;
            state_q <= S_LO_HOLD;
            cnt_q   <= '0;
          end
        end
        S_LO_HOLD: begin
          if (wait_hit) begin
            state_q <= S_WAIT;
            cnt_q   <= '0;
          end
        end
        S_WAIT: begin
          if (wait_hit) begin
            state_q <= S_NEXT;
            cnt_q   <= '0;
          end
        end
        S_NEXT: begin
          cnt_q <= '0;
          if (cmd_ptr_q == LAST_PTR) begin
            done_q    <= 1'b1;
            ready_q   <= 1'b1;
            cmd_ptr_q <= '0;
            state_q   <= S_IDLE;
          end else begin
            cmd_ptr_q <= cmd_ptr_q + 6'd1;
            state_q   <= S_FETCH;
          end
        end
        default: begin
          state_q <= S_PWRUP;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign cmd_ptr_o   = cmd_ptr_q;
  assign lcd_db_o    = lcd_db_q;
  assign lcd_rs_o    = lcd_rs_q;
  assign lcd_rw_o    = 1'b0;
  assign lcd_e_o     = lcd_e_q;
  assign ready_o     = ready_q;
  assign done_o      = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/lcd_refresh_sequencer.md
Name: lcd_refresh_sequencer

Overview:
- Controller that owns the 4-bit HD44780-style character LCD path on the FP multiplier board.
- After reset it runs the LCD power-up/4-bit init. On each start request it walks cmd_ptr through a fixed 44-entry table: 4 config commands, then 40 hex characters.
- The nibble converter supplies the hex nibble for each cmd_ptr; this block converts it to ASCII and strobes it into the LCD.
- All timing is derived from a 1 µs tick enable on clk.

Parameters:
- PWRUP_US, 15000, power-on wait before the first init nibble (µs).
- E_PULSE_US, 1, lcd_e high width (µs, ≥1).
- CMD_WAIT_US, 40, post-byte wait for normal commands and characters (µs).
- CLR_WAIT_US, 1640, post-byte wait after clear display (µs).
- LAST_PTR, 43, final table index (6'h2B).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- us_tick  in  1  one-clk pulse every 1 µs; all delays count these.
- start  in  1  one-clk pulse requesting a full display refresh.
- hex_nibble  in  4  nibble from converter for current cmd_ptr.
- cmd_ptr  out  6  table index presented to converter.
- lcd_db  out  4  LCD data bus DB7..DB4.
- lcd_rs  out  1  0 = command, 1 = character.
- lcd_rw  out  1  tied 0 (write only).
- lcd_e  out  1  LCD enable strobe.
- ready  out  1  init complete and idle; start accepted.
- done  out  1  one-clk pulse at end of refresh.

Behaviour:
- Reset values: cmd_ptr=0, lcd_db=0, lcd_rs=0, lcd_rw=0, lcd_e=0, ready=0, done=0. FSM enters PWRUP with the µs counter cleared.
- Reset mid-operation aborts immediately and reruns PWRUP/INIT. No partial-state retention.
- Delay counter: cleared on every state entry; increments only on us_tick. A wait of N µs means N ticks have been counted.
- PWRUP: wait PWRUP_US, then go to INIT.
- INIT: write four single nibbles with rs=0: 0x3 (wait 4100), 0x3 (wait 100), 0x3 (wait 40), 0x2 (wait 40). Each nibble uses the strobe sequence below. Then go to IDLE with ready=1.
- IDLE: ready=1, lcd_e=0, cmd_ptr=0. On start, set ready=0 and go to FETCH.
- start while ready=0 is ignored and not queued.
- Table, by cmd_ptr:
  - 0 = 0x28 (function set).
  - 1 = 0x06 (entry mode).
  - 2 = 0x0C (display on).
  - 3 = 0x01 (clear; uses CLR_WAIT_US).
  - 4..LAST_PTR = character, rs=1, byte = ASCII(hex_nibble).
- ASCII mapping: 0–9 → 0x30+n; A–F → 0x37+n (0x41..0x46).
- FETCH: hold cmd_ptr stable for 2 us_ticks before latching hex_nibble into a byte register. This covers the converter's one-tick registered output and its buffer reloads at ptr 2/3/11/12/19/20/28/29/36/37.
- Byte write:
  - HI_SETUP: drive lcd_db=byte[7:4] and lcd_rs; wait 1 tick.
  - HI_E: lcd_e=1 for E_PULSE_US ticks.
  - HI_HOLD: lcd_e=0; wait 1 tick.
  - LO_SETUP / LO_E / LO_HOLD: same three steps with byte[3:0].
  - WAIT: CMD_WAIT_US, or CLR_WAIT_US when cmd_ptr==3.
- lcd_db and lcd_rs are unchanged while lcd_e=1.
- NEXT:
  - If cmd_ptr==LAST_PTR: done=1 for one clk, cmd_ptr←0, go to IDLE.
  - Otherwise cmd_ptr←cmd_ptr+1 and go to FETCH. No wrap is possible.
- 40 characters are written contiguously into line-1 DDRAM positions 0x00–0x27.
- us_tick asserted on the same clk as a state entry is not counted for the new state.

Test Plan:
- Reset, then free-run us_tick → first lcd_e rise after ≥15000 ticks with lcd_db=0x3, rs=0. Four init strobes (3,3,3,2) occur, then ready=1. Gap between strobes 1 and 2 is ≥4100 ticks.
- Pulse start with hex_nibble model returning cmd_ptr[3:0] → LCD monitor decodes 0x28, 0x06, 0x0C, 0x01, then 40 characters. ptr=4 gives '4' (0x34); ptr=0x0A gives 'A' (0x41); ptr=0x0F gives 'F' (0x46). Then done pulses once and ready=1.
- Timing check → clear is followed by ≥1640 ticks before the next strobe. Every character is followed by ≥40 ticks. lcd_e high exactly E_PULSE_US ticks. lcd_db/rs stable across every E-high window.
- Pulse start repeatedly while ready=0 → byte count remains exactly 44, one done pulse.
- Assert reset at cmd_ptr=0x15 during LO_E → all outputs return to reset values next clk. The full PWRUP/INIT sequence reruns before ready=1.
- Integrate with the nibble converter holding product 0x3F800000 in entry 0 → characters 4..11 read "3F800000".
